// File: rtl/rx_bert_checker_pkg.sv
// rx_bert_checker_pkg: BERT state encodings and PRBS tap masks
// shared by the Rx checker ways and the Tx pattern generators.
package rx_bert_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEED    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } bert_state_e;

  // Tap positions in the bit window, LSB = oldest bit.
  // next = parity(window & taps), e.g. PRBS31:
  // b[n] = b[n-31] ^ b[n-28].
  function automatic logic [31:0] prbs_taps(
    input int unsigned len
  );
    case (len)
      7:       return 32'h0000_0003;
      15:      return 32'h0000_0003;
      23:      return 32'h0000_0021;
      default: return 32'h0000_0009;
    endcase
  endfunction

endpackage

// File: rtl/prbs_check_way.sv
// prbs_check_way: one way of the Rx BERT checker.
// Optional RX_BERT_FIRST_ERR_EN adds the first_err capture.
module prbs_check_way
  import rx_bert_checker_pkg::*;
#(
  parameter int BitsPerWay = 4,
  parameter int PRBSLength = 31,
  parameter int LockWords  = 16,
  parameter int LossWords  = 4,
  parameter int CntWidth   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clear,
  input  logic [BitsPerWay-1:0] rx,
  output logic                  lock,
  output logic [CntWidth-1:0]   err_cnt,
  output logic [CntWidth-1:0]   bit_cnt
`ifdef RX_BERT_FIRST_ERR_EN
  ,
  output logic [BitsPerWay-1:0] first_err
`endif
);

  localparam int L  = PRBSLength;
  localparam int SW = $clog2(L + BitsPerWay + 1);
  localparam int KW = $clog2(LockWords + 1);
  localparam int OW = $clog2(LossWords + 1);
  localparam int PW = $clog2(BitsPerWay + 1);
  localparam logic [L-1:0] Taps = L'(prbs_taps(L));

  bert_state_e state_q, state_d;

  logic [SW-1:0] seed_q, seed_d, seed_sum;
  logic [L-1:0]  lfsr_q, lfsr_d;
  logic [L-1:0]  lfsr_seed, lfsr_run;
  logic [KW-1:0] good_q, good_d;
  logic [OW-1:0] bad_q, bad_d;

  logic [BitsPerWay-1:0] exp_bits;
  logic [BitsPerWay-1:0] mism;
  logic [PW-1:0]         pop;
  logic                  cnt_en;

  logic [CntWidth-1:0] err_q, bit_q;
  logic [CntWidth:0]   err_sum, bit_sum;

  // Seed window, free-run prediction and mismatch count
  always_comb begin
    lfsr_seed = lfsr_q;
    lfsr_run  = lfsr_q;
    exp_bits  = '0;
    pop       = '0;
    for (int j = 0; j < BitsPerWay; j++) begin
      lfsr_seed   = {rx[j], lfsr_seed[L-1:1]};
      exp_bits[j] = ^(lfsr_run & Taps);
      lfsr_run    = {exp_bits[j], lfsr_run[L-1:1]};
    end
    mism = rx ^ exp_bits;
    for (int j = 0; j < BitsPerWay; j++) begin
      pop = pop + PW'(mism[j]);
    end
    seed_sum = seed_q + SW'(BitsPerWay);
    err_sum  = {1'b0, err_q} + (CntWidth+1)'(pop);
    bit_sum  = {1'b0, bit_q}
             + (CntWidth+1)'(BitsPerWay);
  end

  // SEED -> LOCKING -> LOCKED next-state logic
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    good_d  = good_q;
    bad_d   = bad_q;
    cnt_en  = 1'b0;
    if (!en) begin
      state_d = ST_SEED;
      seed_d  = '0;
      good_d  = '0;
      bad_d   = '0;
    end else begin
      unique case (state_q)
        ST_SEED: begin
          lfsr_d = lfsr_seed;
          if (seed_sum >= SW'(L)) begin
            seed_d = SW'(L);
          end else begin
            seed_d = seed_sum;
          end
          // an all-zero window would lock onto
          // a dead stream, so keep seeding
          if (seed_sum >= SW'(L) && lfsr_seed != '0) begin
            state_d = ST_LOCKING;
            good_d  = '0;
          end
        end
        ST_LOCKING: begin
          lfsr_d = lfsr_run;
          if (mism != '0) begin
            state_d = ST_SEED;
            seed_d  = '0;
          end else if (good_q == KW'(LockWords - 1)) begin
            state_d = ST_LOCKED;
            bad_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          lfsr_d = lfsr_run;
          cnt_en = 1'b1;
          if (mism == '0) begin
            bad_d = '0;
          end else if (bad_q == OW'(LossWords - 1)) begin
            state_d = ST_SEED;
            seed_d  = '0;
          end else begin
            bad_d = bad_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_SEED;
          seed_d  = '0;
        end
      endcase
    end
  end

  // FSM and LFSR state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SEED;
      seed_q  <= '0;
      lfsr_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  // Saturating error/bit counters, clear wins
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_q <= '0;
      bit_q <= '0;
    end else if (cnt_en) begin
      err_q <= err_sum[CntWidth] ? '1
             : err_sum[CntWidth-1:0];
      bit_q <= bit_sum[CntWidth] ? '1
             : bit_sum[CntWidth-1:0];
    end
  end

`ifdef RX_BERT_FIRST_ERR_EN
  logic [BitsPerWay-1:0] fe_q;

  // Capture first errored locked word's mask
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      fe_q <= '0;
    end else if (cnt_en && mism != '0
                 && fe_q == '0) begin
      fe_q <= mism;
    end
  end

  assign first_err = fe_q;
`endif

  assign lock    = (state_q == ST_LOCKED);
  assign err_cnt = err_q;
  assign bit_cnt = bit_q;

endmodule

// File: rtl/rx_bert_checker.sv
// rx_bert_checker: Rx BERT checker, input register + per-way checkers.
// Optional RX_BERT_FIRST_ERR_EN adds the first_err output.
module rx_bert_checker
  import rx_bert_checker_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int Ways       = 2,
  parameter int PRBSLength = 31,
  parameter int LockWords  = 16,
  parameter int LossWords  = 4,
  parameter int CntWidth   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [Ways-1:0]            en,
  input  logic                       clear,
  input  logic [DataWidth-1:0]       data_in,
  output logic [Ways-1:0]            lock,
  output logic [Ways*CntWidth-1:0]   err_cnt,
  output logic [Ways*CntWidth-1:0]   bit_cnt
`ifdef RX_BERT_FIRST_ERR_EN
  ,
  output logic [DataWidth-1:0]       first_err
`endif
);

  localparam int Bpw = DataWidth / Ways;

  logic [DataWidth-1:0] d_q;

  // Stage 1: register the received word
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= '0;
    end else begin
      d_q <= data_in;
    end
  end

  for (genvar i = 0; i < Ways; i++) begin : g_way
    logic [Bpw-1:0] rx;

    for (genvar j = 0; j < Bpw; j++) begin : g_bit
      assign rx[j] = d_q[j*Ways + i];
    end

    prbs_check_way #(
      .BitsPerWay (Bpw),
      .PRBSLength (PRBSLength),
      .LockWords  (LockWords),
      .LossWords  (LossWords),
      .CntWidth   (CntWidth)
    ) u_way (
      .clk       (clk),
      .reset     (reset),
      .en        (en[i]),
      .clear     (clear),
      .rx        (rx),
      .lock      (lock[i]),
      .err_cnt   (err_cnt[CntWidth*i +: CntWidth]),
      .bit_cnt   (bit_cnt[CntWidth*i +: CntWidth])
`ifdef RX_BERT_FIRST_ERR_EN
      ,
      .first_err (first_err[Bpw*i +: Bpw])
`endif
    );
  end

endmodule
